// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan reader.
package seg7_pkg;

    // Segment patterns, seg[6]=a ... seg[0]=g, active-high.
    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_BLANK = 4'hA;
    localparam logic [3:0] BCD_BAD   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Display-side bus of the scan reader: scanned segment/enable lines in, decoded digits out.
interface seg7_scan_reader_if;

    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] bcd_lo;
    logic [3:0] bcd_hi;
    logic       bad_lo;
    logic       bad_hi;
    logic       frame_valid;
    logic       conflict;

    // Display driver / stimulus side.
    modport master (
        output seg, an,
        input  bcd_lo, bcd_hi, bad_lo, bad_hi, frame_valid, conflict
    );

    // Reader side.
    modport slave (
        input  seg, an,
        output bcd_lo, bcd_hi, bad_lo, bad_hi, frame_valid, conflict
    );

endinterface

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD lookup; blank maps to BCD_BLANK, unknown to BCD_BAD.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] val_o,
    output logic       bad_o
);

    // Pattern lookup; anything outside the table is flagged bad.
    always_comb begin
        val_o = BCD_BAD;
        bad_o = 1'b0;
        case (seg_i)
            SEG_0:     val_o = 4'd0;
            SEG_1:     val_o = 4'd1;
            SEG_2:     val_o = 4'd2;
            SEG_3:     val_o = 4'd3;
            SEG_4:     val_o = 4'd4;
            SEG_5:     val_o = 4'd5;
            SEG_6:     val_o = 4'd6;
            SEG_7:     val_o = 4'd7;
            SEG_8:     val_o = 4'd8;
            SEG_9:     val_o = 4'd9;
            SEG_BLANK: val_o = BCD_BLANK;
            default: begin
                val_o = BCD_BAD;
                bad_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Two-digit multiplexed 7-segment reader: waits for each digit's pattern to hold for
// STABLE samples, decodes it, and pulses frame_valid once both digits have refreshed.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE = 4  // legal 2..15
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_reader_if.slave  bus
);

    localparam logic [3:0] RunMax  = 4'(STABLE);
    localparam logic [3:0] RunLast = 4'(STABLE - 1);

    // Input stage plus a one-cycle-older copy used for change detection.
    logic [6:0] s_seg_q, p_seg_q;
    logic [1:0] s_an_q, p_an_q;

    state_e     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [3:0] bcd_lo_q, bcd_lo_d, bcd_hi_q, bcd_hi_d;
    logic       bad_lo_q, bad_lo_d, bad_hi_q, bad_hi_d;
    logic       done_lo_q, done_lo_d, done_hi_q, done_hi_d;
    logic       frame_valid_q, frame_valid_d;

    logic [3:0] dec_val;
    logic       dec_bad;
    logic       conflict;
    logic       changed;
    logic       entry;
    logic       commit;
    logic       done_lo_set, done_hi_set;

    seg7_to_bcd u_dec (
        .seg_i (s_seg_q),
        .val_o (dec_val),
        .bad_o (dec_bad)
    );

    // Register inputs, FSM state, run counter and all output state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg_q       <= '0;
            s_an_q        <= '0;
            p_seg_q       <= '0;
            p_an_q        <= '0;
            state_q       <= S_IDLE;
            run_q         <= '0;
            bcd_lo_q      <= '0;
            bcd_hi_q      <= '0;
            bad_lo_q      <= 1'b0;
            bad_hi_q      <= 1'b0;
            done_lo_q     <= 1'b0;
            done_hi_q     <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            s_seg_q       <= bus.seg;
            s_an_q        <= bus.an;
            p_seg_q       <= s_seg_q;
            p_an_q        <= s_an_q;
            state_q       <= state_d;
            run_q         <= run_d;
            bcd_lo_q      <= bcd_lo_d;
            bcd_hi_q      <= bcd_hi_d;
            bad_lo_q      <= bad_lo_d;
            bad_hi_q      <= bad_hi_d;
            done_lo_q     <= done_lo_d;
            done_hi_q     <= done_hi_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Next state, run counter, commit and frame completion.
    always_comb begin
        state_d       = S_IDLE;
        run_d         = run_q;
        commit        = 1'b0;
        bcd_lo_d      = bcd_lo_q;
        bcd_hi_d      = bcd_hi_q;
        bad_lo_d      = bad_lo_q;
        bad_hi_d      = bad_hi_q;
        done_lo_d     = done_lo_q;
        done_hi_d     = done_hi_q;
        frame_valid_d = 1'b0;

        case (s_an_q)
            2'b01:   state_d = S_LO;
            2'b10:   state_d = S_HI;
            default: state_d = S_IDLE;  // 00 blank, 11 conflict
        endcase

        conflict = (s_an_q == 2'b11);
        changed  = (s_seg_q != p_seg_q) || (s_an_q != p_an_q);
        entry    = (state_d != state_q) && (state_d != S_IDLE);

        if (conflict) begin
            run_d = '0;
        end else if (changed || entry) begin
            run_d = 4'd1;
        end else if (run_q < RunMax) begin
            run_d  = run_q + 4'd1;
            // Only the STABLE-1 -> STABLE step commits, so a held pattern never recommits.
            commit = (run_q == RunLast);
        end

        if (commit && state_d == S_LO) begin
            bcd_lo_d = dec_val;
            bad_lo_d = dec_bad;
        end
        if (commit && state_d == S_HI) begin
            bcd_hi_d = dec_val;
            bad_hi_d = dec_bad;
        end

        // A commit landing on the completing cycle still counts toward this frame.
        done_lo_set = done_lo_q | (commit && state_d == S_LO);
        done_hi_set = done_hi_q | (commit && state_d == S_HI);
        if (done_lo_set && done_hi_set) begin
            frame_valid_d = 1'b1;
            done_lo_d     = 1'b0;
            done_hi_d     = 1'b0;
        end else begin
            done_lo_d     = done_lo_set;
            done_hi_d     = done_hi_set;
        end
    end

    assign bus.bcd_lo      = bcd_lo_q;
    assign bus.bcd_hi      = bcd_hi_q;
    assign bus.bad_lo      = bad_lo_q;
    assign bus.bad_hi      = bad_hi_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.conflict    = conflict;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with STABLE=4.
module tb_seg7_scan_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   fv_cnt = 0;
    int   fv_base;

    seg7_scan_reader_if bus ();

    seg7_scan_reader #(.STABLE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count frame_valid pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_cnt = fv_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present inputs for one clock; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic [6:0] s, input logic [1:0] a);
        bus.seg = s;
        bus.an  = a;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] pats [10];

    initial begin
        pats = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        bus.seg = '0;
        bus.an  = '0;

        // Reset with a live pattern on the bus.
        rst_n = 1'b0;
        repeat (2) cyc(7'h7F, 2'b01);
        check_val("rst_bcd_lo", 32'(bus.bcd_lo), 32'd0);
        check_val("rst_bcd_hi", 32'(bus.bcd_hi), 32'd0);
        check_val("rst_bad", {30'd0, bus.bad_hi, bus.bad_lo}, 32'd0);
        check_val("rst_fv", 32'(bus.frame_valid), 32'd0);
        check_val("rst_conflict", 32'(bus.conflict), 32'd0);
        rst_n = 1'b1;
        repeat (4) cyc(7'h7F, 2'b01);
        check_val("rst_no_early_commit", 32'(bus.bcd_lo), 32'd0);
        cyc(7'h7F, 2'b01);
        check_val("rst_commit_8", 32'(bus.bcd_lo), 32'd8);

        // Frame: units 3 then tens 5.
        repeat (5) cyc(7'h79, 2'b01);
        check_val("frame_lo", 32'(bus.bcd_lo), 32'd3);
        check_val("frame_fv_lo", 32'(bus.frame_valid), 32'd0);
        repeat (4) cyc(7'h5B, 2'b10);
        check_val("frame_hi_early", 32'(bus.bcd_hi), 32'd0);
        check_val("frame_fv_early", 32'(bus.frame_valid), 32'd0);
        cyc(7'h5B, 2'b10);
        check_val("frame_hi", 32'(bus.bcd_hi), 32'd5);
        check_val("frame_fv", 32'(bus.frame_valid), 32'd1);
        check_val("frame_bad", {30'd0, bus.bad_hi, bus.bad_lo}, 32'd0);
        cyc(7'h00, 2'b00);
        check_val("frame_fv_one_cycle", 32'(bus.frame_valid), 32'd0);

        // Glitch rejection.
        repeat (3) cyc(7'h30, 2'b01);
        cyc(7'h7F, 2'b01);
        repeat (3) cyc(7'h30, 2'b01);
        check_val("glitch_no_commit", 32'(bus.bcd_lo), 32'd3);
        cyc(7'h30, 2'b01);
        check_val("glitch_still_none", 32'(bus.bcd_lo), 32'd3);
        cyc(7'h00, 2'b00);
        check_val("glitch_commit_1", 32'(bus.bcd_lo), 32'd1);

        // Invalid, then blank, on the tens digit.
        repeat (5) cyc(7'h01, 2'b10);
        check_val("invalid_hi", 32'(bus.bcd_hi), 32'hF);
        check_val("invalid_bad_hi", 32'(bus.bad_hi), 32'd1);
        repeat (5) cyc(7'h00, 2'b10);
        check_val("blank_hi", 32'(bus.bcd_hi), 32'hA);
        check_val("blank_bad_hi", 32'(bus.bad_hi), 32'd0);

        // Conflict.
        cyc(7'h7E, 2'b11);
        check_val("conflict_1", 32'(bus.conflict), 32'd1);
        cyc(7'h7E, 2'b11);
        check_val("conflict_2", 32'(bus.conflict), 32'd1);
        cyc(7'h7E, 2'b00);
        check_val("conflict_off", 32'(bus.conflict), 32'd0);
        repeat (5) cyc(7'h7E, 2'b00);
        check_val("conflict_no_commit_lo", 32'(bus.bcd_lo), 32'd1);
        check_val("conflict_no_commit_hi", 32'(bus.bcd_hi), 32'hA);

        // Mid-run reset.
        repeat (3) cyc(7'h33, 2'b01);
        check_val("midrst_pre", 32'(bus.bcd_lo), 32'd1);
        rst_n = 1'b0;
        cyc(7'h33, 2'b01);
        rst_n = 1'b1;
        check_val("midrst_bcd_lo", 32'(bus.bcd_lo), 32'd0);
        check_val("midrst_bcd_hi", 32'(bus.bcd_hi), 32'd0);
        check_val("midrst_fv", 32'(bus.frame_valid), 32'd0);
        repeat (6) cyc(7'h00, 2'b00);
        check_val("midrst_no_commit", 32'(bus.bcd_lo), 32'd0);

        // Lockstep sweep 0..9, 6-cycle dwells.
        fv_base = fv_cnt;
        for (int i = 0; i < 10; i++) begin
            repeat (6) cyc(pats[i], 2'b01);
            repeat (6) cyc(pats[i], 2'b10);
            check_val($sformatf("sweep_lo_%0d", i), 32'(bus.bcd_lo), 32'(i));
            check_val($sformatf("sweep_hi_%0d", i), 32'(bus.bcd_hi), 32'(i));
        end
        check_val("sweep_frames", 32'(fv_cnt - fv_base), 32'd10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
